// File: rtl/wb_arbiter_rr.sv
// N-master to 1-slave Wishbone round-robin arbiter with registered grant.
// Define WB_ARB_TIMEOUT_EN to terminate hung slave accesses with ERR after TIMEOUT cycles.
module wb_arbiter_rr #(
   parameter int unsigned NM      = 2,
   parameter int unsigned AW      = 30,
   parameter int unsigned DW      = 32,
   parameter int unsigned SW      = DW / 8,
   parameter int unsigned GW      = (NM > 1) ? $clog2(NM) : 1,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [NM*AW-1:0] m_adr_i,
   input  logic [NM*DW-1:0] m_dat_i,
   input  logic [NM*SW-1:0] m_sel_i,
   input  logic [NM-1:0]    m_cyc_i,
   input  logic [NM-1:0]    m_stb_i,
   input  logic [NM-1:0]    m_we_i,
   input  logic [NM*3-1:0]  m_cti_i,
   input  logic [NM*2-1:0]  m_bte_i,
   output logic [DW-1:0]    m_dat_o,
   output logic [NM-1:0]    m_ack_o,
   output logic [NM-1:0]    m_err_o,
   output logic [AW-1:0]    s_adr_o,
   output logic [DW-1:0]    s_dat_o,
   output logic [SW-1:0]    s_sel_o,
   output logic             s_cyc_o,
   output logic             s_stb_o,
   output logic             s_we_o,
   output logic [2:0]       s_cti_o,
   output logic [1:0]       s_bte_o,
   input  logic [DW-1:0]    s_dat_i,
   input  logic             s_ack_i,
   input  logic             s_err_i,
   output logic [GW-1:0]    grant_o,
   output logic             timeout_o
);

   localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);

   logic [GW-1:0] grant_q, grant_d;
   logic [NM-1:0] gnt_oh;
   logic          cyc_sel;
   logic          stb_sel;
   logic          to_fire;

   // Slave port mirrors the current owner; there is no idle/no-owner state.
   always_comb begin
      int unsigned g;
      g       = 32'(grant_q);
      s_adr_o = m_adr_i[g*AW +: AW];
      s_dat_o = m_dat_i[g*DW +: DW];
      s_sel_o = m_sel_i[g*SW +: SW];
      s_cti_o = m_cti_i[g*3 +: 3];
      s_bte_o = m_bte_i[g*2 +: 2];
      s_we_o  = m_we_i[grant_q];
      cyc_sel = m_cyc_i[grant_q];
      stb_sel = m_stb_i[grant_q];
      s_cyc_o = cyc_sel;
      s_stb_o = stb_sel;
      m_dat_o = s_dat_i;
      grant_o = grant_q;
   end

   always_comb begin
      gnt_oh  = {{(NM-1){1'b0}}, 1'b1} << grant_q;
      m_ack_o = {NM{s_ack_i}} & gnt_oh;
      m_err_o = {NM{s_err_i | to_fire}} & gnt_oh;
   end

   // Scan starts one past the owner, so the releasing master is considered last.
   always_comb begin
      int unsigned sum;
      logic        found;
      grant_d = grant_q;
      found   = 1'b0;
      sum     = 0;
      if (!cyc_sel) begin
         for (int unsigned i = 1; i <= NM; i++) begin
            sum = 32'(grant_q) + i;
            if (sum >= NM) begin
               sum = sum - NM;
            end
            if (!found && m_cyc_i[sum[GW-1:0]]) begin
               grant_d = sum[GW-1:0];
               found   = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         grant_q <= '0;
      end else begin
         grant_q <= grant_d;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        to_flag_q, to_flag_d;

   // A genuine ACK/ERR in the final cycle wins over the forced error.
   always_comb begin
      to_fire = cyc_sel & stb_sel & ~s_ack_i & ~s_err_i & (to_cnt_q == ToLast);
      if (!cyc_sel || s_ack_i || s_err_i || (grant_d != grant_q) || to_fire) begin
         to_cnt_d = '0;
      end else if (stb_sel) begin
         to_cnt_d = to_cnt_q + 16'd1;
      end else begin
         to_cnt_d = to_cnt_q;
      end
      to_flag_d = to_flag_q | to_fire;
      timeout_o = to_flag_q;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
      end
   end
`else
   logic unused_to_last;

   always_comb begin
      to_fire        = 1'b0;
      timeout_o      = 1'b0;
      unused_to_last = ^ToLast;
   end
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed self-checking bench for wb_arbiter_rr (NM=4 and NM=3 instances).
module tb_wb_arbiter_rr;

`ifdef WB_ARB_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // NM=4 instance signals
   logic [31:0] c_adr;
   logic [63:0] c_dat;
   logic [7:0]  c_sel;
   logic [3:0]  c_cyc, c_stb, c_we;
   logic [11:0] c_cti;
   logic [7:0]  c_bte;
   logic [15:0] c_m_dat;
   logic [3:0]  c_m_ack, c_m_err;
   logic [7:0]  c_s_adr;
   logic [15:0] c_s_dat;
   logic [1:0]  c_s_sel;
   logic        c_s_cyc, c_s_stb, c_s_we;
   logic [2:0]  c_s_cti;
   logic [1:0]  c_s_bte;
   logic [15:0] c_s_dat_i;
   logic        c_ack, c_err;
   logic [1:0]  c_grant;
   logic        c_to;

   // NM=3 instance signals
   logic [23:0] r_adr;
   logic [47:0] r_dat;
   logic [5:0]  r_sel;
   logic [2:0]  r_cyc, r_stb, r_we;
   logic [8:0]  r_cti;
   logic [5:0]  r_bte;
   logic [15:0] r_m_dat;
   logic [2:0]  r_m_ack, r_m_err;
   logic [7:0]  r_s_adr;
   logic [15:0] r_s_dat;
   logic [1:0]  r_s_sel;
   logic        r_s_cyc, r_s_stb, r_s_we;
   logic [2:0]  r_s_cti;
   logic [1:0]  r_s_bte;
   logic        r_ack;
   logic [1:0]  r_grant;
   logic        r_to;

   wb_arbiter_rr #(.NM(4), .AW(8), .DW(16), .TIMEOUT(8)) u4 (
      .sys_clk(clk), .sys_rst(rst),
      .m_adr_i(c_adr), .m_dat_i(c_dat), .m_sel_i(c_sel), .m_cyc_i(c_cyc),
      .m_stb_i(c_stb), .m_we_i(c_we), .m_cti_i(c_cti), .m_bte_i(c_bte),
      .m_dat_o(c_m_dat), .m_ack_o(c_m_ack), .m_err_o(c_m_err),
      .s_adr_o(c_s_adr), .s_dat_o(c_s_dat), .s_sel_o(c_s_sel), .s_cyc_o(c_s_cyc),
      .s_stb_o(c_s_stb), .s_we_o(c_s_we), .s_cti_o(c_s_cti), .s_bte_o(c_s_bte),
      .s_dat_i(c_s_dat_i), .s_ack_i(c_ack), .s_err_i(c_err),
      .grant_o(c_grant), .timeout_o(c_to)
   );

   wb_arbiter_rr #(.NM(3), .AW(8), .DW(16)) u3 (
      .sys_clk(clk), .sys_rst(rst),
      .m_adr_i(r_adr), .m_dat_i(r_dat), .m_sel_i(r_sel), .m_cyc_i(r_cyc),
      .m_stb_i(r_stb), .m_we_i(r_we), .m_cti_i(r_cti), .m_bte_i(r_bte),
      .m_dat_o(r_m_dat), .m_ack_o(r_m_ack), .m_err_o(r_m_err),
      .s_adr_o(r_s_adr), .s_dat_o(r_s_dat), .s_sel_o(r_s_sel), .s_cyc_o(r_s_cyc),
      .s_stb_o(r_s_stb), .s_we_o(r_s_we), .s_cti_o(r_s_cti), .s_bte_o(r_s_bte),
      .s_dat_i(16'h0), .s_ack_i(r_ack), .s_err_i(1'b0),
      .grant_o(r_grant), .timeout_o(r_to)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      c_cyc = '0; c_stb = '0; c_cti = '0; c_ack = 1'b0; c_err = 1'b0; c_s_dat_i = 16'h5A3C;
      for (int k = 0; k < 4; k++) begin
         c_adr[k*8 +: 8]   = 8'h10 + 8'(k);
         c_dat[k*16 +: 16] = 16'hA000 + 16'(k);
         c_sel[k*2 +: 2]   = 2'(k);
         c_we[k]           = k[0];
         c_bte[k*2 +: 2]   = 2'(3 - k);
      end
      r_adr = 24'h221100; r_dat = '0; r_sel = '0; r_cyc = '0; r_stb = '0; r_we = '0;
      r_cti = '0; r_bte = '0; r_ack = 1'b0;

      // Reset, no requests
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_grant", 32'(c_grant), 32'd0);
      chk("rst_s_cyc", 32'(c_s_cyc), 32'd0);
      chk("rst_s_adr", 32'(c_s_adr), 32'h10);
      chk("rst_ack", 32'(c_m_ack), 32'd0);
      chk("rst_err", 32'(c_m_err), 32'd0);
      chk("rst_to", 32'(c_to), 32'd0);
      chk("rst_dat_bcast", 32'(c_m_dat), 32'h5A3C);

      // Masters 1 and 3 request together; 1 wins, then 3, then 1 again
      tick(); c_cyc = 4'b1010; c_stb = 4'b1010; #1;
      chk("req_latency_grant", 32'(c_grant), 32'd0);
      tick();
      chk("rr_first_grant", 32'(c_grant), 32'd1);
      chk("rr_first_adr", 32'(c_s_adr), 32'h11);
      chk("rr_first_dat", 32'(c_s_dat), 32'hA001);
      chk("rr_first_we", 32'(c_s_we), 32'd1);
      chk("rr_first_bte", 32'(c_s_bte), 32'd2);
      c_ack = 1'b1; #1;
      chk("rr_first_ack", 32'(c_m_ack), 32'b0010);
      tick(); c_ack = 1'b0; c_cyc[1] = 1'b0; c_stb[1] = 1'b0;
      tick();
      chk("rr_second_grant", 32'(c_grant), 32'd3);
      chk("rr_second_adr", 32'(c_s_adr), 32'h13);
      c_cyc[1] = 1'b1; c_stb[1] = 1'b1;
      tick();
      chk("owner_holds", 32'(c_grant), 32'd3);
      c_cyc[3] = 1'b0; c_stb[3] = 1'b0;
      tick();
      chk("rr_third_grant", 32'(c_grant), 32'd1);
      c_cyc[1] = 1'b0; c_stb[1] = 1'b0;
      tick();
      chk("no_req_hold", 32'(c_grant), 32'd1);

      // Master 2 burst while master 0 waits
      c_cyc = 4'b0101; c_stb = 4'b0101; c_cti[2*3 +: 3] = 3'b010;
      tick();
      chk("burst_grant", 32'(c_grant), 32'd2);
      for (int b = 0; b < 4; b++) begin
         if (b == 3) c_cti[2*3 +: 3] = 3'b111;
         c_ack = 1'b1; #1;
         chk("burst_owner", 32'(c_grant), 32'd2);
         chk("burst_ack", 32'(c_m_ack), 32'b0100);
         chk("burst_cti", 32'(c_s_cti), (b == 3) ? 32'b111 : 32'b010);
         tick();
      end
      c_ack = 1'b0; c_cyc[2] = 1'b0; c_stb[2] = 1'b0; c_cti = '0;
      tick();
      chk("after_burst_grant", 32'(c_grant), 32'd0);
      chk("after_burst_cyc", 32'(c_s_cyc), 32'd1);
      c_cyc[0] = 1'b0; c_stb[0] = 1'b0;

      // Hung slave on master 1
      tick(); c_cyc[1] = 1'b1; c_stb[1] = 1'b1;
      tick();
      chk("hang_grant", 32'(c_grant), 32'd1);
      for (int c = 1; c < 8; c++) begin
         #1;
         chk("hang_no_err_early", 32'(c_m_err), 32'd0);
         tick();
      end
      #1;
      chk("hang_err_cycle8", 32'(c_m_err), ToEn ? 32'b0010 : 32'd0);
      chk("hang_to_cycle8", 32'(c_to), 32'd0);
      tick();
      chk("hang_err_cycle9", 32'(c_m_err), 32'd0);
      chk("hang_to_set", 32'(c_to), ToEn ? 32'd1 : 32'd0);
      c_cyc[1] = 1'b0; c_stb[1] = 1'b0; c_cyc[2] = 1'b1; c_stb[2] = 1'b1;
      tick();
      chk("to_sticky", 32'(c_to), ToEn ? 32'd1 : 32'd0);
      chk("pending_grant2", 32'(c_grant), 32'd2);

      // Reset mid-transfer with master 2 still requesting
      rst = 1'b1;
      tick();
      chk("midrst_grant", 32'(c_grant), 32'd0);
      chk("midrst_to", 32'(c_to), 32'd0);
      chk("midrst_s_cyc", 32'(c_s_cyc), 32'd0);
      rst = 1'b0; c_cyc[2] = 1'b0; c_stb[2] = 1'b0;
      tick();
      chk("postrst_grant", 32'(c_grant), 32'd0);

      // Slave acks on the 8th strobed cycle: no forced error
      c_cyc[1] = 1'b1; c_stb[1] = 1'b1;
      tick();
      for (int c = 1; c < 8; c++) begin
         #1;
         chk("ack8_no_err_early", 32'(c_m_err), 32'd0);
         tick();
      end
      c_ack = 1'b1; #1;
      chk("ack8_err", 32'(c_m_err), 32'd0);
      chk("ack8_ack", 32'(c_m_ack), 32'b0010);
      tick(); c_ack = 1'b0; #1;
      chk("ack8_err_after", 32'(c_m_err), 32'd0);
      chk("ack8_to", 32'(c_to), 32'd0);
      c_cyc[1] = 1'b0; c_stb[1] = 1'b0;

      // NM=3 fairness: all request, each releases after one ACK
      for (int t = 0; t < 6; t++) begin
         tick();
         r_cyc = 3'b111; r_stb = 3'b111; #1;
         chk("rr3_grant", 32'(r_grant), 32'(t % 3));
         r_ack = 1'b1; #1;
         chk("rr3_ack", 32'(r_m_ack), 32'(3'b001 << (t % 3)));
         chk("rr3_err", 32'(r_m_err), 32'd0);
         tick();
         r_ack = 1'b0; r_cyc[t % 3] = 1'b0; r_stb[t % 3] = 1'b0;
      end
      r_cyc = '0; r_stb = '0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
